branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline.
- It replaces fixed predict-not-taken fetch, where the ID-resolved branch or jump flushes IF.
- IF performs a same-cycle lookup on the fetch PC and gets a predicted next PC. ID resolution writes back outcome and target one cycle later.
- The block holds a direct-mapped BTB and a pattern table of saturating counters. It runs in bimodal or gshare mode.

Parameters:
- ADDR_W, 32, PC/target width.
- ENTRIES, 64, BTB and pattern table depth; power of two, >=4.
- CTR_W, 2, saturating counter width; 1..3.
- MODE, 0, 0 = bimodal (pattern index = PC index); 1 = gshare (pattern index = PC index XOR GHR).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- lk_pc  in  ADDR_W  fetch PC to predict.
- pred_hit  out  1  BTB tag match, entry valid.
- pred_taken  out  1  predict redirect.
- pred_target  out  ADDR_W  predicted target; 0 when pred_hit=0.
- pred_idx  out  IDX_W  pattern index used; the pipeline carries it to ID.
- upd_valid  in  1  resolved branch/jump this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_idx  in  IDX_W  pred_idx captured at that instruction's fetch.
- upd_taken  in  1  actual outcome.
- upd_is_jump  in  1  unconditional jump.
- upd_target  in  ADDR_W  resolved target.

Behaviour:
- IDX_W = $clog2(ENTRIES).
- BTB index bi = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- BTB entry = {valid, is_jump, tag, target}.
- GHR is IDX_W bits wide and exists only when MODE=1.
- Lookup is combinational, zero latency:
  - pred_hit = valid[bi] && tag match.
  - pred_idx = bi (MODE 0) or bi ^ GHR (MODE 1).
  - pred_taken = pred_hit && (is_jump[bi] || ctr[pred_idx] MSB).
  - pred_target = pred_hit ? target[bi] : 0.
- Lookup never bypasses an update. A lookup in the same cycle as an update to the same entry sees pre-update state.
- Update is registered and takes effect at the rising edge where upd_valid=1.
- Counter update (conditional branches only, upd_is_jump=0):
  - ctr[upd_idx] increments on taken and saturates at 2^CTR_W-1.
  - ctr[upd_idx] decrements on not-taken and saturates at 0.
  - Jumps never touch counters.
- BTB update:
  - If upd_taken=1 or upd_is_jump=1: write entry at bi(upd_pc) with valid=1, is_jump=upd_is_jump, tag, target=upd_target. This overwrites any aliasing entry.
  - Not-taken branch: BTB is unchanged and nothing is allocated.
- GHR update (MODE 1): on upd_valid with upd_is_jump=0, GHR <= {GHR[IDX_W-2:0], upd_taken}. GHR is non-speculative and updates at resolution only.
- upd_valid=0: no state change.
- Reset (reset_n=0 at a rising edge):
  - All valid bits clear; is_jump, tag and target clear.
  - All counters set to weakly-not-taken, 2^(CTR_W-1)-1.
  - GHR cleared.
  - Reset takes one edge; there is no init FSM.
- While reset_n=0, pred_hit, pred_taken, pred_target and pred_idx are all forced to 0.
- Reset dominates a simultaneous upd_valid, and the update is dropped.
- Reset mid-stream loses all history with no residue.
- Integrator note: the pipeline compares pred_taken/pred_target with the ID resolution. A flush happens on mismatch, not on every taken branch. That logic is outside this block.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W default;
  - MODE_BIMODAL=0 and MODE_GSHARE=1 constants;
  - btb_entry_t struct {valid, is_jump, tag, target};
  - function ctr_init(CTR_W).
- One natural sub-module: sat_counter (CTR_W-wide, inc/dec/init, saturating), instantiated ENTRIES times via generate.
- The BTB array stays inline.

Test Plan:
- Reset, then lookup lk_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0, pred_idx=0x10. During reset_n=0 with upd_valid=1 -> no state change is visible after release.
- Bimodal, CTR_W=2: one taken update pc=0x40 target=0x80 -> counter 1->2; lookup 0x40 -> hit=1, taken=1, target=0x80.
- Saturation: 3 more taken updates -> counter 3. 1 not-taken -> 2, still taken. 1 more not-taken -> 1, lookup taken=0 and hit=1. 3 more not-taken -> stays 0.
- Alias and jump: update jump pc=0x40 target=0x200, then taken branch pc=0x40+ENTRIES*4 target=0x300. Lookup 0x40 -> hit=0. Lookup the aliasing PC -> hit=1, target=0x300. Also: not-taken update of a missing PC -> no allocation.
- Same-cycle update and lookup of pc=0x40 -> lookup returns the old value; the next cycle returns the new value.
- Gshare, MODE=1: updates of taken, taken, not-taken -> GHR=3'b110 (low bits). Lookup 0x40 -> pred_idx=0x10^GHR. Update with that upd_idx moves only that counter, and the counter at 0x10 is untouched.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address width default, predictor modes,
// BTB entry layout and counter reset value.
`default_nettype none

package cpu_pkg;

   localparam int ADDR_W_DEFAULT = 32;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;

   // Tag and target are sized for the widest supported PC; narrower
   // configurations zero-extend into these fields.
   typedef struct packed {
      logic                      valid;
      logic                      is_jump;
      logic [ADDR_W_DEFAULT-1:0] tag;
      logic [ADDR_W_DEFAULT-1:0] target;
   } btb_entry_t;

   // Weakly-not-taken value for a counter of the given width (1..3 bits).
   function automatic logic [2:0] ctr_init(input int ctr_w);
      return 3'((1 << (ctr_w - 1)) - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter; the MSB is the taken prediction.
`default_nettype none

module sat_counter
   import cpu_pkg::*;
#(
   parameter int CTR_W = 2
)(
   input  logic clock,
   input  logic reset_n,
   input  logic inc,
   input  logic dec,
   output logic taken
);

   localparam logic [CTR_W-1:0] INIT = CTR_W'(ctr_init(CTR_W));
   localparam logic [CTR_W-1:0] MAX  = '1;

   logic [CTR_W-1:0] value;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         value <= INIT;
      end else if (inc && (value != MAX)) begin
         value <= value + 1'b1;
      end else if (dec && (value != '0)) begin
         value <= value - 1'b1;
      end
   end

   assign taken = value[CTR_W-1];

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus saturating-counter pattern table, bimodal or gshare
// indexed, with zero-latency lookup and registered resolution update.
`default_nettype none

module branch_predictor
   import cpu_pkg::*;
#(
   parameter  int ADDR_W  = ADDR_W_DEFAULT,
   parameter  int ENTRIES = 64,
   parameter  int CTR_W   = 2,
   parameter  int MODE    = MODE_BIMODAL,
   localparam int IDX_W   = $clog2(ENTRIES)
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic              upd_is_jump,
   input  logic [ADDR_W-1:0] upd_target
);

   btb_entry_t btb [ENTRIES];

   logic [IDX_W-1:0]          lk_bi;
   logic [IDX_W-1:0]          upd_bi;
   logic [ADDR_W_DEFAULT-1:0] lk_tag;
   logic [ADDR_W_DEFAULT-1:0] upd_tag;
   logic [IDX_W-1:0]          ghr;
   logic [IDX_W-1:0]          pat_idx;
   logic [ENTRIES-1:0]        ctr_taken;
   logic [ENTRIES-1:0]        ctr_inc;
   logic [ENTRIES-1:0]        ctr_dec;
   btb_entry_t                lk_entry;
   btb_entry_t                new_entry;
   logic                      hit_raw;
   logic                      ctr_write;
   logic                      btb_write;
   logic                      unused_bits;

   assign lk_bi   = lk_pc[IDX_W+1:2];
   assign upd_bi  = upd_pc[IDX_W+1:2];
   assign lk_tag  = ADDR_W_DEFAULT'(lk_pc[ADDR_W-1:IDX_W+2]);
   assign upd_tag = ADDR_W_DEFAULT'(upd_pc[ADDR_W-1:IDX_W+2]);

   // Instruction alignment bits carry no information for prediction.
   assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0]};

   assign ctr_write = upd_valid && !upd_is_jump;
   assign btb_write = upd_valid && (upd_taken || upd_is_jump);

   generate
      if (MODE == MODE_GSHARE) begin : g_gshare
         logic [IDX_W-1:0] ghr_q;
         always_ff @(posedge clock) begin
            if (!reset_n) begin
               ghr_q <= '0;
            end else if (ctr_write) begin
               ghr_q <= {ghr_q[IDX_W-2:0], upd_taken};
            end
         end
         assign ghr = ghr_q;
      end else begin : g_bimodal
         assign ghr = '0;
      end
   endgenerate

   generate
      for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
         assign ctr_inc[i] = ctr_write &&  upd_taken && (upd_idx == IDX_W'(i));
         assign ctr_dec[i] = ctr_write && !upd_taken && (upd_idx == IDX_W'(i));

         sat_counter #(
            .CTR_W (CTR_W)
         ) u_ctr (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (ctr_inc[i]),
            .dec     (ctr_dec[i]),
            .taken   (ctr_taken[i])
         );
      end
   endgenerate

   always_comb begin
      new_entry         = '0;
      new_entry.valid   = 1'b1;
      new_entry.is_jump = upd_is_jump;
      new_entry.tag     = upd_tag;
      new_entry.target  = ADDR_W_DEFAULT'(upd_target);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb[i] <= '0;
         end
      end else if (btb_write) begin
         btb[upd_bi] <= new_entry;
      end
   end

   // Lookup reads pre-edge state, so a same-cycle update is not forwarded.
   assign lk_entry = btb[lk_bi];
   assign pat_idx  = lk_bi ^ ghr;
   assign hit_raw  = lk_entry.valid && (lk_entry.tag == lk_tag);

   always_comb begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = '0;
      pred_idx    = '0;
      if (reset_n) begin
         pred_hit    = hit_raw;
         pred_taken  = hit_raw && (lk_entry.is_jump || ctr_taken[pat_idx]);
         pred_target = hit_raw ? ADDR_W'(lk_entry.target) : '0;
         pred_idx    = pat_idx;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor in bimodal and gshare configurations.
`default_nettype none

module tb_branch_predictor;

   logic clock = 1'b0;
   logic reset_n;

   logic [31:0] b_lk_pc, b_upd_pc, b_upd_target, b_pred_target;
   logic [5:0]  b_upd_idx, b_pred_idx;
   logic        b_upd_valid, b_upd_taken, b_upd_is_jump, b_pred_hit, b_pred_taken;

   logic [31:0] g_lk_pc, g_upd_pc, g_upd_target, g_pred_target;
   logic [5:0]  g_upd_idx, g_pred_idx;
   logic        g_upd_valid, g_upd_taken, g_upd_is_jump, g_pred_hit, g_pred_taken;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   branch_predictor #(.ADDR_W(32), .ENTRIES(64), .CTR_W(2), .MODE(0)) dut_b (
      .clock       (clock),
      .reset_n     (reset_n),
      .lk_pc       (b_lk_pc),
      .pred_hit    (b_pred_hit),
      .pred_taken  (b_pred_taken),
      .pred_target (b_pred_target),
      .pred_idx    (b_pred_idx),
      .upd_valid   (b_upd_valid),
      .upd_pc      (b_upd_pc),
      .upd_idx     (b_upd_idx),
      .upd_taken   (b_upd_taken),
      .upd_is_jump (b_upd_is_jump),
      .upd_target  (b_upd_target)
   );

   branch_predictor #(.ADDR_W(32), .ENTRIES(64), .CTR_W(2), .MODE(1)) dut_g (
      .clock       (clock),
      .reset_n     (reset_n),
      .lk_pc       (g_lk_pc),
      .pred_hit    (g_pred_hit),
      .pred_taken  (g_pred_taken),
      .pred_target (g_pred_target),
      .pred_idx    (g_pred_idx),
      .upd_valid   (g_upd_valid),
      .upd_pc      (g_upd_pc),
      .upd_idx     (g_upd_idx),
      .upd_taken   (g_upd_taken),
      .upd_is_jump (g_upd_is_jump),
      .upd_target  (g_upd_target)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One update, applied at the rising edge between two falling edges.
   task automatic do_upd(input bit g, input logic [31:0] pc, input logic [5:0] idx,
                         input logic taken, input logic jump, input logic [31:0] tgt);
      @(negedge clock);
      if (g) begin
         g_upd_valid = 1'b1; g_upd_pc = pc; g_upd_idx = idx;
         g_upd_taken = taken; g_upd_is_jump = jump; g_upd_target = tgt;
      end else begin
         b_upd_valid = 1'b1; b_upd_pc = pc; b_upd_idx = idx;
         b_upd_taken = taken; b_upd_is_jump = jump; b_upd_target = tgt;
      end
      @(negedge clock);
      g_upd_valid = 1'b0;
      b_upd_valid = 1'b0;
   endtask

   task automatic look(input bit g, input string tag, input logic [31:0] pc,
                       input logic hit, input logic taken, input logic [31:0] tgt,
                       input logic [5:0] idx);
      if (g) g_lk_pc = pc; else b_lk_pc = pc;
      #1;
      check({tag, ".hit"},    g ? g_pred_hit    : b_pred_hit,    hit);
      check({tag, ".taken"},  g ? g_pred_taken  : b_pred_taken,  taken);
      check({tag, ".target"}, g ? g_pred_target : b_pred_target, tgt);
      check({tag, ".idx"},    g ? g_pred_idx    : b_pred_idx,    idx);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      g_lk_pc = '0; g_upd_valid = 1'b0; g_upd_pc = '0; g_upd_idx = '0;
      g_upd_taken = 1'b0; g_upd_is_jump = 1'b0; g_upd_target = '0;
      // An update held during reset must be dropped.
      b_lk_pc = 32'h40; b_upd_valid = 1'b1; b_upd_pc = 32'h40; b_upd_idx = 6'h10;
      b_upd_taken = 1'b1; b_upd_is_jump = 1'b0; b_upd_target = 32'h80;
      repeat (3) @(negedge clock);
      look(0, "in_reset", 32'h40, 0, 0, 32'h0, 6'h00);
      reset_n = 1'b1;
      b_upd_valid = 1'b0;
      look(0, "post_reset", 32'h40, 0, 0, 32'h0, 6'h10);

      // Bimodal counter at index 0x10 starts at 1.
      do_upd(0, 32'h40, 6'h10, 1, 0, 32'h80);
      look(0, "first_taken", 32'h40, 1, 1, 32'h80, 6'h10);
      for (int k = 0; k < 3; k++) do_upd(0, 32'h40, 6'h10, 1, 0, 32'h80);
      do_upd(0, 32'h40, 6'h10, 0, 0, 32'h0);
      look(0, "sat_hi_nt1", 32'h40, 1, 1, 32'h80, 6'h10);
      do_upd(0, 32'h40, 6'h10, 0, 0, 32'h0);
      look(0, "sat_hi_nt2", 32'h40, 1, 0, 32'h80, 6'h10);
      for (int k = 0; k < 3; k++) do_upd(0, 32'h40, 6'h10, 0, 0, 32'h0);
      look(0, "sat_lo", 32'h40, 1, 0, 32'h80, 6'h10);
      do_upd(0, 32'h40, 6'h10, 1, 0, 32'h80);
      look(0, "sat_lo_t1", 32'h40, 1, 0, 32'h80, 6'h10);
      do_upd(0, 32'h40, 6'h10, 1, 0, 32'h80);
      look(0, "sat_lo_t2", 32'h40, 1, 1, 32'h80, 6'h10);

      // Same-cycle update and lookup: old target now, new target next cycle.
      @(negedge clock);
      b_upd_valid = 1'b1; b_upd_pc = 32'h40; b_upd_idx = 6'h10;
      b_upd_taken = 1'b1; b_upd_is_jump = 1'b0; b_upd_target = 32'h90;
      look(0, "same_cycle_old", 32'h40, 1, 1, 32'h80, 6'h10);
      @(negedge clock);
      b_upd_valid = 1'b0;
      look(0, "same_cycle_new", 32'h40, 1, 1, 32'h90, 6'h10);

      // Jump entry, then an aliasing branch evicts it.
      do_upd(0, 32'h40, 6'h10, 1, 1, 32'h200);
      look(0, "jump", 32'h40, 1, 1, 32'h200, 6'h10);
      do_upd(0, 32'h140, 6'h10, 1, 0, 32'h300);
      look(0, "alias_evicted", 32'h40, 0, 0, 32'h0, 6'h10);
      look(0, "alias_new", 32'h140, 1, 1, 32'h300, 6'h10);

      // Jump must not move counter 0x21 (starts at 1).
      do_upd(0, 32'h84, 6'h21, 1, 1, 32'h400);
      look(0, "jump2", 32'h84, 1, 1, 32'h400, 6'h21);
      do_upd(0, 32'h84, 6'h21, 1, 0, 32'h500);
      do_upd(0, 32'h84, 6'h21, 0, 0, 32'h0);
      look(0, "jump_no_ctr", 32'h84, 1, 0, 32'h500, 6'h21);
      do_upd(0, 32'h88, 6'h22, 0, 0, 32'h0);
      look(0, "nt_no_alloc", 32'h88, 0, 0, 32'h0, 6'h22);

      // Mid-stream reset clears all BTB state.
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      look(0, "midreset_140", 32'h140, 0, 0, 32'h0, 6'h10);
      look(0, "midreset_84", 32'h84, 0, 0, 32'h0, 6'h21);

      // Gshare: history taken, taken, not-taken gives GHR = 6'b000110.
      do_upd(1, 32'h40, 6'h10, 1, 0, 32'h80);
      do_upd(1, 32'h0C, 6'h05, 1, 0, 32'hC0);
      do_upd(1, 32'h300, 6'h05, 0, 0, 32'h0);
      look(1, "gs_ghr110", 32'h40, 1, 0, 32'h80, 6'h16);
      do_upd(1, 32'h40, 6'h16, 1, 0, 32'h80);
      // Rebuild GHR = 000110 using a scratch counter at 0x3F.
      do_upd(1, 32'h300, 6'h3F, 0, 0, 32'h0);
      do_upd(1, 32'h300, 6'h3F, 0, 0, 32'h0);
      do_upd(1, 32'h300, 6'h3F, 0, 0, 32'h0);
      do_upd(1, 32'h300, 6'h3F, 1, 0, 32'h0);
      do_upd(1, 32'h300, 6'h3F, 1, 0, 32'h0);
      do_upd(1, 32'h300, 6'h3F, 0, 0, 32'h0);
      look(1, "gs_ctr16", 32'h40, 1, 1, 32'h80, 6'h16);
      for (int k = 0; k < 6; k++) do_upd(1, 32'h300, 6'h3F, 0, 0, 32'h0);
      look(1, "gs_ctr10", 32'h40, 1, 1, 32'h80, 6'h10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
